freq_meter: RTL and testbench

//  Measures an external square wave: frequency, period and high time.

---
 rtl/freq_meter_pkg.sv | 21 ++
 rtl/freq_meter_sync_edge_det.sv | 30 +++
 rtl/freq_meter.sv | 113 +++++++++++
 tb/tb_freq_meter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the frequency/period meter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } per_state_e;

  localparam int unsigned GATE_CYC_DEF    = 32'd100_000_000;
  localparam int unsigned TIMEOUT_CYC_DEF = 32'd200_000_000;
  localparam int unsigned SAT_W           = 64;

  // Increment v, clamping at the all-ones value of a w-bit counter (w <= 64).
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v, input int unsigned w);
    logic [SAT_W-1:0] top;
    top = (w >= SAT_W) ? '1 : ((SAT_W'(1) << w) - SAT_W'(1));
    return (v >= top) ? top : v + SAT_W'(1);
  endfunction

endpackage

// File: rtl/freq_meter_sync_edge_det.sv
// Synchroniser for an asynchronous level plus single-cycle rise/fall strobes.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~s_d;
  assign fall  = ~level & s_d;

endmodule

// File: rtl/freq_meter.sv
// Square-wave meter: rising edges per gate window, plus period and high time
// of each input cycle, with a no-signal timeout.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int          CNT_W       = 32,
  parameter int unsigned GATE_CYC    = GATE_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_cnt,
  output logic             freq_valid,
  output logic [CNT_W-1:0] period_cyc,
  output logic [CNT_W-1:0] high_cyc,
  output logic             period_valid,
  output logic             no_signal
);

  // Gate counter is sized by the gate length, not CNT_W, so a narrow result
  // width can still use a long gate.
  localparam int               GATE_W    = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(SAT_W'(v), CNT_W));
  endfunction

  logic rise, fall, lvl_unused;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sig_in),
    .level (lvl_unused),
    .rise  (rise),
    .fall  (fall)
  );

  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic              gate_term;

  assign gate_term = (gate_cnt == GATE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      freq_cnt   <= '0;
      freq_valid <= 1'b0;
    end else begin
      freq_valid <= gate_term;
      if (gate_term) begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        // a rise landing on the terminal cycle belongs to the closing window
        freq_cnt <= rise ? inc(edge_cnt) : edge_cnt;
      end else begin
        gate_cnt <= gate_cnt + GATE_W'(1);
        if (rise) edge_cnt <= inc(edge_cnt);
      end
    end
  end

  per_state_e       state;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] hi_cap;
  logic             timeout;

  // A rise on the timeout cycle takes priority over the timeout.
  assign timeout = (state != IDLE) && !rise && (per_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      per_cnt      <= '0;
      hi_cap       <= '0;
      period_cyc   <= '0;
      high_cyc     <= '0;
      period_valid <= 1'b0;
      no_signal    <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      per_cnt      <= rise ? '0 : inc(per_cnt);
      if (fall) hi_cap <= inc(per_cnt);
      if (timeout) begin
        state      <= IDLE;
        no_signal  <= 1'b1;
        period_cyc <= '0;
        high_cyc   <= '0;
      end else begin
        case (state)
          IDLE:  if (rise) state <= ARMED;
          ARMED: if (rise) state <= RUN;
          RUN: begin
            if (rise) begin
              period_cyc   <= inc(per_cnt);
              high_cyc     <= hi_cap;
              period_valid <= 1'b1;
              no_signal    <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench: DUT a at a scaled gate/timeout with a 500-cycle input
// period, DUT b with 8-bit counters driven at half the clock rate.
module tb_freq_meter;

  localparam int GATE = 5000;
  localparam int TO   = 1500;
  localparam int PER  = 500;

  logic        clk, rst_n, sig_a, sig_b;
  logic [31:0] freq_cnt_a, period_cyc_a, high_cyc_a;
  logic        fv_a, pv_a, ns_a;
  logic [7:0]  freq_cnt_b, period_cyc_b, high_cyc_b;
  logic        fv_b, pv_b, ns_b;

  freq_meter #(.CNT_W(32), .GATE_CYC(GATE), .TIMEOUT_CYC(TO), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_a),
    .freq_cnt(freq_cnt_a), .freq_valid(fv_a),
    .period_cyc(period_cyc_a), .high_cyc(high_cyc_a),
    .period_valid(pv_a), .no_signal(ns_a)
  );

  freq_meter #(.CNT_W(8), .GATE_CYC(1000), .TIMEOUT_CYC(200), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_b),
    .freq_cnt(freq_cnt_b), .freq_valid(fv_b),
    .period_cyc(period_cyc_b), .high_cyc(high_cyc_b),
    .period_valid(pv_b), .no_signal(ns_b)
  );

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  logic gen_en;
  int hi_len;
  int hi_q[$];
  int pv_cnt = 0, pv_first = -1;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Input generators: sig_a starts each period high for hi_len cycles.
  initial begin
    int ph;
    ph = 0; sig_a = 0; sig_b = 0;
    forever begin
      @(posedge clk); #1;
      if (!gen_en) begin
        sig_a = 0; ph = 0; sig_b = 0;
      end else begin
        if (ph == 0) hi_q.push_back(cyc);
        sig_a = (ph < hi_len);
        ph    = (ph + 1 >= PER) ? 0 : ph + 1;
        sig_b = ~sig_b;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (pv_a) begin
      pv_cnt++;
      if (pv_first < 0) pv_first = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_fv(output int at);
    at = -1;
    for (int i = 0; i < GATE + 20; i++) begin
      @(negedge clk);
      if (fv_a) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk("fv_timeout", 1, 0);
  endtask

  initial begin
    int r, at, pv0, t, n0, g, exp_t;
    rst_n = 0; gen_en = 0; hi_len = 250;
    repeat (5) @(negedge clk);
    chk("rst_freq_cnt", freq_cnt_a, 0);
    chk("rst_freq_valid", fv_a, 0);
    chk("rst_period", period_cyc_a, 0);
    chk("rst_high", high_cyc_a, 0);
    chk("rst_pv", pv_a, 0);
    chk("rst_no_signal", ns_a, 0);

    gen_en = 1;
    @(posedge clk); #1 rst_n = 1; r = cyc;

    // First rise strobe lands at gate_cnt 2; rises every PER -> 10 per gate.
    wait_fv(at);
    chk("fv_latency", at - r, GATE);
    chk("freq_50", freq_cnt_a, 10);
    // rises at +2 (ARMED), +502 (RUN), +1002 first update, visible next cycle
    chk("pv_first", pv_first - r, 1003);
    chk("period_50", period_cyc_a, 500);
    chk("high_50", high_cyc_a, 250);
    chk("no_signal_run", ns_a, 0);
    chk("b_freq_sat", freq_cnt_b, 255);
    chk("b_period", period_cyc_b, 2);
    chk("b_high", high_cyc_b, 1);
    wait_fv(at);
    chk("freq_50_w2", freq_cnt_a, 10);

    @(negedge clk) hi_len = 150;
    wait_fv(at);
    pv0 = pv_cnt;
    wait_fv(at);
    chk("pv_per_gate", pv_cnt - pv0, 10);
    chk("freq_30", freq_cnt_a, 10);
    chk("period_30", period_cyc_a, 500);
    chk("high_30", high_cyc_a, 150);

    // Stop: rise strobe at hi+2, timeout cycle TO later, flag visible next cycle.
    @(negedge clk) gen_en = 0;
    t = -1;
    for (int i = 0; i < 3 * TO; i++) begin
      @(negedge clk);
      if (ns_a) begin t = cyc; break; end
    end
    chk("ns_delay", t - (hi_q[$] + 2), TO + 1);
    chk("ns_period", period_cyc_a, 0);
    chk("ns_high", high_cyc_a, 0);
    wait_fv(at);
    wait_fv(at);
    chk("ns_freq", freq_cnt_a, 0);

    // Restart: flag clears on the third rise (the first one processed in RUN).
    n0 = hi_q.size();
    @(negedge clk) gen_en = 1;
    t = -1;
    for (int i = 0; i < 4 * PER; i++) begin
      @(negedge clk);
      if (!ns_a) begin t = cyc; break; end
    end
    exp_t = (hi_q.size() > n0 + 2) ? hi_q[n0 + 2] + 3 : -2;
    chk("ns_clear", t, exp_t);
    chk("restart_period", period_cyc_a, 500);

    // Place a rise strobe exactly on the terminal cycle of a silent window.
    @(negedge clk) gen_en = 0;
    wait_fv(at);
    g = at + GATE - 3;
    while (cyc < g - 1) @(negedge clk);
    gen_en = 1;
    wait_fv(at);
    chk("term_closing", freq_cnt_a, 1);
    wait_fv(at);
    chk("term_next", freq_cnt_a, 10);

    // Async reset mid-gate and mid-period.
    repeat (2250) @(negedge clk);
    chk("pre_rst_period", period_cyc_a, 500);
    @(posedge clk); #2 rst_n = 0;
    #1;
    chk("arst_freq", freq_cnt_a, 0);
    chk("arst_period", period_cyc_a, 0);
    chk("arst_high", high_cyc_a, 0);
    chk("arst_b_freq", freq_cnt_b, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1; r = cyc;
    wait_fv(at);
    chk("fv_latency_rst", at - r, GATE);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
